// File: rtl/calc_pkg.sv
// Shared definitions for the calculator front end: op-codes, operand width
// and the debouncer state type.
package calc_pkg;

  localparam int unsigned OPW = 4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_e;

endpackage

// File: rtl/calc_input_conditioner_sync.sv
// Multi-flop synchroniser bringing an asynchronous bus into the clk domain.
module bit_synchronizer #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stg [STAGES];

  // Plain flop chain; nothing may sit between stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) stg[i] <= '0;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < STAGES; i++) stg[i] <= stg[i-1];
    end
  end

  assign q = stg[STAGES-1];

endmodule

// File: rtl/calc_input_conditioner.sv
// Synchronises and debounces {btn, sw} as one vector and presents committed
// operands / op-code with a one-cycle update strobe.
module calc_input_conditioner
  import calc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sw,
  input  logic [1:0] btn,
  output logic [7:0] sw_o,
  output logic [1:0] op_o,
  output logic       upd_o,
  output logic       busy_o
);

  localparam int unsigned VW = 2 * OPW + 2;
  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [VW-1:0] sync_vec;

  state_e        state_q, state_d;
  logic [VW-1:0] cand_q, cand_d;
  logic [VW-1:0] comm_q, comm_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          upd_q, upd_d;
  logic          busy_q, busy_d;

  bit_synchronizer #(
    .WIDTH  (VW),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({btn, sw}),
    .q     (sync_vec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cand_q  <= '0;
      comm_q  <= '0;
      cnt_q   <= '0;
      upd_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      comm_q  <= comm_d;
      cnt_q   <= cnt_d;
      upd_q   <= upd_d;
      busy_q  <= busy_d;
    end
  end

  // Any bounce restarts the window; a commit back to the old value is silent.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    comm_d  = comm_q;
    cnt_d   = cnt_q;
    upd_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sync_vec != comm_q) begin
          cand_d  = sync_vec;
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (sync_vec != cand_q) begin
          cand_d = sync_vec;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          comm_d  = cand_q;
          upd_d   = (cand_q != comm_q);
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SETTLE);
  end

  assign sw_o   = comm_q[7:0];
  assign op_o   = comm_q[9:8];
  assign upd_o  = upd_q;
  assign busy_o = busy_q;

endmodule
